// File: rtl/systolic_pp_array.sv
// systolic_pp_array: N1xN2 output-stationary systolic MAC array with internal operand skew
// and a serial westward drain per row. Optional macro SATURATE_EN clamps accumulation.
module systolic_pp_array #(
   parameter int D_W     = 8,
   parameter int D_W_ACC = 32,
   parameter int N1      = 4,
   parameter int N2      = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   input  logic                  in_first,
   input  logic [N1*D_W-1:0]     A,
   input  logic [N2*D_W-1:0]     B,
   output logic [N1*D_W_ACC-1:0] D,
   output logic [N1-1:0]         valid_D,
   output logic                  err_overrun
);

   logic signed [D_W-1:0]     ask_q [N1][N1];
   logic signed [D_W-1:0]     ask_d [N1][N1];
   logic signed [D_W-1:0]     bsk_q [N2][N2];
   logic signed [D_W-1:0]     bsk_d [N2][N2];
   logic signed [D_W-1:0]     a_q   [N1][N2];
   logic signed [D_W-1:0]     a_d   [N1][N2];
   logic signed [D_W-1:0]     b_q   [N1][N2];
   logic signed [D_W-1:0]     b_d   [N1][N2];
   logic                      v_q   [N1][N2];
   logic                      v_d   [N1][N2];
   logic                      f_q   [N1][N2];
   logic                      f_d   [N1][N2];
   logic signed [D_W_ACC-1:0] acc_q [N1][N2];
   logic signed [D_W_ACC-1:0] acc_d [N1][N2];
   logic                      has_q [N1][N2];
   logic                      has_d [N1][N2];
   logic signed [D_W_ACC-1:0] res_q [N1][N2];
   logic signed [D_W_ACC-1:0] res_d [N1][N2];
   logic                      rv_q  [N1][N2];
   logic                      rv_d  [N1][N2];
   logic                      err_q;
   logic                      err_d;

   // Row i reaches column 0 through i skew stages, column j reaches row 0 through j;
   // valid/first ride with the operands so PE(i,j) sees a step i+j edges late.
   always_comb begin
      ask_d = '{default: '0};
      bsk_d = '{default: '0};
      a_d   = '{default: '0};
      b_d   = '{default: '0};
      v_d   = '{default: 1'b0};
      f_d   = '{default: 1'b0};
      for (int unsigned i = 0; i < N1; i++) begin
         ask_d[i][0] = A[i*D_W +: D_W];
         for (int unsigned k = 1; k < N1; k++) ask_d[i][k] = ask_q[i][k-1];
      end
      for (int unsigned j = 0; j < N2; j++) begin
         bsk_d[j][0] = B[j*D_W +: D_W];
         for (int unsigned k = 1; k < N2; k++) bsk_d[j][k] = bsk_q[j][k-1];
      end
      a_d[0][0] = A[0 +: D_W];
      b_d[0][0] = B[0 +: D_W];
      v_d[0][0] = in_valid;
      f_d[0][0] = in_first;
      for (int unsigned i = 1; i < N1; i++) begin
         a_d[i][0] = ask_q[i][i-1];
         b_d[i][0] = b_q[i-1][0];
         v_d[i][0] = v_q[i-1][0];
         f_d[i][0] = f_q[i-1][0];
      end
      for (int unsigned j = 1; j < N2; j++) begin
         b_d[0][j] = bsk_q[j][j-1];
         for (int unsigned i = 0; i < N1; i++) begin
            a_d[i][j] = a_q[i][j-1];
            v_d[i][j] = v_q[i][j-1];
            f_d[i][j] = f_q[i][j-1];
            if (i > 0) b_d[i][j] = b_q[i-1][j];
         end
      end
   end

   always_comb begin
      logic signed [2*D_W-1:0]   prod;
      logic signed [D_W_ACC-1:0] pext;
      logic signed [D_W_ACC-1:0] acc_sum;
`ifdef SATURATE_EN
      logic [D_W_ACC:0]          sum_x;
      sum_x   = '0;
`endif
      prod    = '0;
      pext    = '0;
      acc_sum = '0;
      acc_d   = acc_q;
      has_d   = has_q;
      err_d   = err_q;
      res_d   = '{default: '0};
      rv_d    = '{default: 1'b0};
      for (int unsigned i = 0; i < N1; i++) begin
         for (int unsigned j = 0; j + 1 < N2; j++) begin
            res_d[i][j] = res_q[i][j+1];
            rv_d[i][j]  = rv_q[i][j+1];
         end
      end
      for (int unsigned i = 0; i < N1; i++) begin
         for (int unsigned j = 0; j < N2; j++) begin
            prod = (2*D_W)'(a_q[i][j]) * (2*D_W)'(b_q[i][j]);
            pext = D_W_ACC'(prod);
`ifdef SATURATE_EN
            sum_x = {acc_q[i][j][D_W_ACC-1], acc_q[i][j]} + {pext[D_W_ACC-1], pext};
            if (sum_x[D_W_ACC] != sum_x[D_W_ACC-1])
               acc_sum = sum_x[D_W_ACC] ? {1'b1, {(D_W_ACC-1){1'b0}}} : {1'b0, {(D_W_ACC-1){1'b1}}};
            else
               acc_sum = sum_x[D_W_ACC-1:0];
`else
            acc_sum = acc_q[i][j] + pext;
`endif
            if (f_q[i][j]) begin
               acc_d[i][j] = v_q[i][j] ? pext : '0;
               has_d[i][j] = v_q[i][j];
               // Closing a tile overwrites whatever was shifting in from the east.
               if (rv_d[i][j]) err_d = 1'b1;
               res_d[i][j] = acc_q[i][j];
               rv_d[i][j]  = has_q[i][j];
            end else if (v_q[i][j]) begin
               acc_d[i][j] = acc_sum;
               has_d[i][j] = 1'b1;
            end
         end
      end
   end

   always_comb begin
      D       = '0;
      valid_D = '0;
      for (int unsigned i = 0; i < N1; i++) begin
         D[i*D_W_ACC +: D_W_ACC] = res_q[i][0];
         valid_D[i]              = rv_q[i][0];
      end
   end

   assign err_overrun = err_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         ask_q <= '{default: '0};
         bsk_q <= '{default: '0};
         a_q   <= '{default: '0};
         b_q   <= '{default: '0};
         v_q   <= '{default: 1'b0};
         f_q   <= '{default: 1'b0};
         acc_q <= '{default: '0};
         has_q <= '{default: 1'b0};
         res_q <= '{default: '0};
         rv_q  <= '{default: 1'b0};
         err_q <= 1'b0;
      end else begin
         ask_q <= ask_d;
         bsk_q <= bsk_d;
         a_q   <= a_d;
         b_q   <= b_d;
         v_q   <= v_d;
         f_q   <= f_d;
         acc_q <= acc_d;
         has_q <= has_d;
         res_q <= res_d;
         rv_q  <= rv_d;
         err_q <= err_d;
      end
   end

endmodule
